miriscv_decode_bpu: RTL and testbench
=====================================

Name: miriscv_decode_bpu

Overview:
- Parametrised dynamic branch predictor that replaces the static jump-only prediction in the decode stage.
- Decode queries it combinationally with the current instruction's PC and type, and receives a taken/not-taken prediction.
- Execute sends resolved branch outcomes back to train a table of saturating counters (BHT) and to update performance counters.
- Table contents are cleared by a sequential sweep FSM after reset or on request (e.g. fence.i).

Parameters:
- XLEN, 32, data/PC width.
- BHT_ENTRIES, 64, number of predictor entries; power of 2, at least 2. IDX_W = $clog2(BHT_ENTRIES).
- CNT_W, 2, saturating counter width; at least 1.
- BTFN_FALLBACK, 1, 1: a branch whose entry is not valid predicts backward-taken/forward-not-taken; 0: such a branch predicts not-taken.
- PERF_W, 32, width of the performance counters.

Ports:
- clk_i, input, 1, clock.
- arstn_i, input, 1, reset; asynchronous, active-low.
- clear_i, input, 1, synchronous request to restart the table-clear sweep.
- busy_o, output, 1, high while the sweep is in progress.
- lk_pc_i, input, XLEN, PC of the instruction in decode.
- lk_branch_i, input, 1, instruction is a conditional branch.
- lk_jal_i, input, 1, instruction is JAL.
- lk_jalr_i, input, 1, instruction is JALR.
- lk_back_i, input, 1, branch immediate is negative (imm_b[XLEN-1]).
- lk_taken_o, output, 1, prediction (combinational).
- upd_valid_i, input, 1, resolved control-transfer from execute.
- upd_pc_i, input, XLEN, PC of the resolved instruction.
- upd_branch_i, input, 1, resolved instruction is a conditional branch.
- upd_taken_i, input, 1, actual outcome.
- upd_pred_i, input, 1, prediction that was made for this instruction.
- mispredict_o, output, 1, combinational: upd_valid_i & (upd_pred_i != upd_taken_i).
- perf_br_cnt_o, output, PERF_W, number of branches resolved.
- perf_mis_cnt_o, output, PERF_W, number of mispredicted branches resolved.

Behaviour:
- Index: idx = pc[IDX_W+1:2]. The same mapping applies to lookup and update.
- Storage: per entry, a CNT_W-bit counter and a valid bit. Storage has no reset; it is initialised only by the sweep.
- FSM states: INIT and RUN.
- Async reset: state=INIT, sweep_idx=0, perf counters=0.
- INIT, each cycle: entry[sweep_idx].cnt = 2^(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1), valid=0, sweep_idx++.
  - After the write to entry BHT_ENTRIES-1, state goes to RUN and sweep_idx returns to 0.
  - The sweep takes exactly BHT_ENTRIES cycles.
- busy_o = (state==INIT). busy_o is 1 out of reset.
- clear_i in any state (including mid-INIT): next state=INIT, sweep_idx=0, perf counters=0. Any update in the same cycle is dropped.
- Lookup priority:
  - jal: taken=1.
  - jalr: taken=0.
  - branch with RUN and entry valid: taken=cnt[CNT_W-1].
  - branch otherwise (entry not valid, or state INIT): taken = BTFN_FALLBACK ? lk_back_i : 0.
  - No control-transfer flag set: taken=0.
  - Multiple flags set simultaneously: jal > jalr > branch.
- Update, applied only when RUN & upd_valid_i & upd_branch_i & ~clear_i:
  - taken: cnt saturating increment (max 2^CNT_W-1).
  - not-taken: cnt saturating decrement (min 0).
  - valid bit set to 1.
  - Updates while in INIT are dropped.
- Update with upd_valid_i & ~upd_branch_i (jal/jalr): no table change.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value. No bypass.
- Perf counters, in RUN & ~clear_i:
  - perf_br_cnt_o increments on every upd_valid_i & upd_branch_i.
  - perf_mis_cnt_o increments on those same events when upd_pred_i != upd_taken_i.
  - Both counters saturate at all-ones and do not wrap.
- Latency: lookup is 0 cycles. An update is visible to lookup on the next cycle.
- Registered outputs (busy_o, perf counters) are glitch-free.

Test Plan:
- Reset, then idle with BHT_ENTRIES=64 -> busy_o=1 for exactly 64 cycles, then 0. A branch lookup with lk_back_i=1 gives taken=1 and with lk_back_i=0 gives taken=0, both during and after the sweep.
- In RUN, two taken updates to PC 0x100 (CNT_W=2, counter 1->2->3) -> lookup of PC 0x100 gives taken=1 with lk_back_i=0. Three not-taken updates -> counter saturates at 0, lookup gives 0. A further not-taken update leaves the counter at 0.
- Aliasing with BHT_ENTRIES=64: a taken update at PC 0x104 -> lookup of PC 0x204 (same idx 1) returns entry state. Lookup of PC 0x108 is unaffected.
- Same cycle: taken update plus lookup on a weakly-not-taken valid entry -> lookup=0 in that cycle, 1 in the next cycle (counter 1->2).
- clear_i asserted mid-sweep (sweep_idx=20) together with an update -> sweep restarts at 0, busy_o stays high 64 more cycles, update dropped, perf counters=0.
- PERF_W=4: 20 mispredicted branch updates -> perf_br_cnt_o=perf_mis_cnt_o=15 (saturated). mispredict_o pulses on each. A jal update (upd_branch_i=0) changes neither counter.

Source files
------------

// File: rtl/miriscv_decode_bpu.sv
// miriscv_decode_bpu: dynamic branch predictor (saturating-counter BHT) for the decode stage.
//   clk_i, arstn_i         clock, asynchronous active-low reset
//   clear_i, busy_o        restart table-clear sweep / sweep in progress
//   lk_*                   combinational lookup from decode (pc, type flags, backward bit) -> lk_taken_o
//   upd_*                  resolved outcome from execute, trains the table
//   mispredict_o           combinational mispredict flag for the update port
//   perf_br_cnt_o          saturating count of resolved branches
//   perf_mis_cnt_o         saturating count of mispredicted branches
module miriscv_decode_bpu #(
    parameter int XLEN          = 32,
    parameter int BHT_ENTRIES   = 64,
    parameter int CNT_W         = 2,
    parameter bit BTFN_FALLBACK = 1'b1,
    parameter int PERF_W        = 32
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              clear_i,
    output logic              busy_o,
    input  logic [XLEN-1:0]   lk_pc_i,
    input  logic              lk_branch_i,
    input  logic              lk_jal_i,
    input  logic              lk_jalr_i,
    input  logic              lk_back_i,
    output logic              lk_taken_o,
    input  logic              upd_valid_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic              upd_branch_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i,
    output logic              mispredict_o,
    output logic [PERF_W-1:0] perf_br_cnt_o,
    output logic [PERF_W-1:0] perf_mis_cnt_o
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    // weakly not-taken; evaluates to 0 for a 1-bit counter
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_ENTRIES - 1);

    logic [CNT_W-1:0]       cnt_q [BHT_ENTRIES];
    logic [BHT_ENTRIES-1:0] vld_q;
    logic [0:0]             state_q, state_d;
    logic [IDX_W-1:0]       sweep_q, sweep_d;
    logic [PERF_W-1:0]      br_q, br_d, mis_q, mis_d;

    logic [IDX_W-1:0] lk_idx, upd_idx, wr_idx;
    logic [CNT_W-1:0] upd_cnt, wr_cnt;
    logic             run, upd_br, upd_en, wr_en, wr_vld;

    assign lk_idx  = lk_pc_i[IDX_W+1:2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign run     = state_q == RUN;
    assign upd_br  = upd_valid_i & upd_branch_i;
    assign upd_en  = run & upd_br & ~clear_i;

    assign busy_o         = ~run;
    assign mispredict_o   = upd_valid_i & (upd_pred_i != upd_taken_i);
    assign perf_br_cnt_o  = br_q;
    assign perf_mis_cnt_o = mis_q;

    // Lookup reads the table before this cycle's update lands (no bypass).
    always_comb begin
        lk_taken_o = lk_jal_i    ? 1'b1 :
                     lk_jalr_i   ? 1'b0 :
                     lk_branch_i ? ((run && vld_q[lk_idx]) ? cnt_q[lk_idx][CNT_W-1] : (BTFN_FALLBACK & lk_back_i)) :
                                   1'b0;
    end

    always_comb begin
        upd_cnt = upd_taken_i ? ((cnt_q[upd_idx] == '1) ? cnt_q[upd_idx] : cnt_q[upd_idx] + CNT_W'(1)) :
                                ((cnt_q[upd_idx] == '0) ? cnt_q[upd_idx] : cnt_q[upd_idx] - CNT_W'(1));
        // The sweep owns the write port while in INIT; training only happens in RUN.
        wr_en  = ~run | upd_en;
        wr_idx = run ? upd_idx : sweep_q;
        wr_cnt = run ? upd_cnt : CNT_INIT;
        wr_vld = run;
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        br_d    = br_q;
        mis_d   = mis_q;
        if (clear_i) begin
            state_d = INIT;
            sweep_d = '0;
            br_d    = '0;
            mis_d   = '0;
        end else if (!run) begin
            sweep_d = sweep_q + IDX_W'(1);
            state_d = (sweep_q == IDX_LAST) ? RUN : INIT;
        end else if (upd_br) begin
            br_d  = (&br_q) ? br_q : br_q + PERF_W'(1);
            mis_d = (mispredict_o && !(&mis_q)) ? mis_q + PERF_W'(1) : mis_q;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= INIT;
            sweep_q <= '0;
            br_q    <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

    // Table storage is deliberately unreset; the sweep initialises it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            cnt_q[wr_idx] <= wr_cnt;
            vld_q[wr_idx] <= wr_vld;
        end
    end
endmodule

// File: tb/tb_miriscv_decode_bpu.sv
// tb_miriscv_decode_bpu: directed plus randomized checks of miriscv_decode_bpu against a table-level model.
module tb_miriscv_decode_bpu;
    localparam int N  = 64;
    localparam int PW = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk_i = 1'b0;
    logic          arstn_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          busy_o;
    logic [31:0]   lk_pc_i = '0;
    logic          lk_branch_i = 1'b0, lk_jal_i = 1'b0, lk_jalr_i = 1'b0, lk_back_i = 1'b0;
    logic          lk_taken_o;
    logic          upd_valid_i = 1'b0;
    logic [31:0]   upd_pc_i = '0;
    logic          upd_branch_i = 1'b0, upd_taken_i = 1'b0, upd_pred_i = 1'b0;
    logic          mispredict_o;
    logic [PW-1:0] perf_br_cnt_o, perf_mis_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt [N];
    bit m_vld [N];
    int m_sweep;
    int m_br, m_mis;

    always #5 clk_i = ~clk_i;

    miriscv_decode_bpu #(
        .XLEN(32), .BHT_ENTRIES(N), .CNT_W(2), .BTFN_FALLBACK(1'b1), .PERF_W(PW)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .clear_i(clear_i), .busy_o(busy_o),
        .lk_pc_i(lk_pc_i), .lk_branch_i(lk_branch_i), .lk_jal_i(lk_jal_i),
        .lk_jalr_i(lk_jalr_i), .lk_back_i(lk_back_i), .lk_taken_o(lk_taken_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_branch_i(upd_branch_i),
        .upd_taken_i(upd_taken_i), .upd_pred_i(upd_pred_i), .mispredict_o(mispredict_o),
        .perf_br_cnt_o(perf_br_cnt_o), .perf_mis_cnt_o(perf_mis_cnt_o)
    );

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit exp_taken();
        int k = idx_of(lk_pc_i);
        if (lk_jal_i) return 1'b1;
        if (lk_jalr_i) return 1'b0;
        if (lk_branch_i) return (m_sweep >= N && m_vld[k]) ? (m_cnt[k] >= 2) : lk_back_i;
        return 1'b0;
    endfunction

    task automatic check1(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check1("lk_taken", 32'(lk_taken_o), 32'(exp_taken()));
        check1("mispredict", 32'(mispredict_o), 32'(upd_valid_i && (upd_pred_i != upd_taken_i)));
        check1("busy", 32'(busy_o), 32'(m_sweep < N));
        check1("perf_br", 32'(perf_br_cnt_o), 32'(m_br));
        check1("perf_mis", 32'(perf_mis_cnt_o), 32'(m_mis));
    endtask

    task automatic model_reset();
        m_sweep = 0;
        m_br = 0;
        m_mis = 0;
    endtask

    task automatic model_edge();
        int k;
        if (clear_i) begin
            model_reset();
        end else if (m_sweep < N) begin
            m_sweep++;
            if (m_sweep == N)
                for (int i = 0; i < N; i++) begin
                    m_cnt[i] = 1;
                    m_vld[i] = 1'b0;
                end
        end else if (upd_valid_i && upd_branch_i) begin
            k = idx_of(upd_pc_i);
            m_cnt[k] = upd_taken_i ? ((m_cnt[k] < 3) ? m_cnt[k] + 1 : 3) : ((m_cnt[k] > 0) ? m_cnt[k] - 1 : 0);
            m_vld[k] = 1'b1;
            if (m_br < PMAX) m_br++;
            if (upd_pred_i != upd_taken_i && m_mis < PMAX) m_mis++;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        check_all();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic lk(logic [31:0] pc, bit br, bit back, bit jal, bit jalr);
        lk_pc_i = pc;
        lk_branch_i = br;
        lk_back_i = back;
        lk_jal_i = jal;
        lk_jalr_i = jalr;
    endtask

    task automatic upd(bit v, logic [31:0] pc, bit br, bit taken, bit pred);
        upd_valid_i = v;
        upd_pc_i = pc;
        upd_branch_i = br;
        upd_taken_i = taken;
        upd_pred_i = pred;
    endtask

    initial begin
        // async reset asserted away from a clock edge
        #2 arstn_i = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk_i);
        #1 arstn_i = 1'b1;

        // sweep: busy for exactly N cycles; fallback lookups during and after
        for (int i = 0; i < N + 6; i++) begin
            lk(32'h100 + 32'(i * 4), 1'b1, i[0], 1'b0, 1'b0);
            step();
        end

        // training at 0x100: 1->2->3 taken, then down to 0 and saturate
        lk(32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        upd(1'b1, 32'h100, 1'b1, 1'b1, 1'b0); step(); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); step();
        upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1); step(); step(); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); step();
        upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b0); step();
        upd(1'b1, 32'h100, 1'b1, 1'b1, 1'b0); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); step();
        upd(1'b1, 32'h100, 1'b1, 1'b1, 1'b0); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); step();

        // aliasing: 0x104 and 0x204 share an index, 0x108 does not
        upd(1'b1, 32'h104, 1'b1, 1'b1, 1'b0); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        lk(32'h204, 1'b1, 1'b0, 1'b0, 1'b0); step();
        lk(32'h108, 1'b1, 1'b0, 1'b0, 1'b0); step();
        lk(32'h108, 1'b1, 1'b1, 1'b0, 1'b0); step();

        // jal > jalr > branch priority, and no-flag lookup
        lk(32'h204, 1'b1, 1'b0, 1'b1, 1'b1); step();
        lk(32'h204, 1'b1, 1'b1, 1'b0, 1'b1); step();
        lk(32'h204, 1'b0, 1'b1, 1'b0, 1'b0); step();

        // same-cycle update and lookup: pre-update value, then new value
        upd(1'b1, 32'h10C, 1'b1, 1'b1, 1'b0); step();
        upd(1'b1, 32'h10C, 1'b1, 1'b0, 1'b1); step();
        lk(32'h10C, 1'b1, 1'b0, 1'b0, 1'b0);
        upd(1'b1, 32'h10C, 1'b1, 1'b1, 1'b0); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); step();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            lk(32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 1) << 8),
               1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            upd(1'($urandom), 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 1) << 8),
                ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
            clear_i = ($urandom_range(0, 99) == 0);
            step();
        end
        clear_i = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        while (m_sweep < N) step();

        // clear in RUN, then clear again mid-sweep together with an update
        clear_i = 1'b1;
        upd(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        step();
        clear_i = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        lk(32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        clear_i = 1'b1;
        upd(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        step();
        clear_i = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N + 2; i++) step();

        // jal update changes no counter; then saturate both perf counters
        upd(1'b1, 32'h100, 1'b0, 1'b1, 1'b0); step();
        for (int i = 0; i < 20; i++) begin
            upd(1'b1, 32'h100 + 32'(i * 4), 1'b1, i[0], ~i[0]);
            step();
        end
        upd(1'b1, 32'h100, 1'b0, 1'b0, 1'b1); step();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); step();

        // async reset mid-run clears perf counters and restarts the sweep
        #2 arstn_i = 1'b0;
        model_reset();
        #1;
        check_all();
        #3 arstn_i = 1'b1;
        @(posedge clk_i);
        model_edge();
        #1;
        lk(32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
